// File: rtl/mix_col_if.sv
// Valid/ready bundle for the MixColumns engine: an input state channel and a result channel.
// The master modport is the side that supplies states and consumes results.
interface mix_col_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, inv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, inv, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_col_engine.sv
// Shared forward/inverse AES MixColumns engine over a full 128-bit state.
// It transforms COLS_PER_CYCLE columns per RUN cycle and holds the result until downstream takes it.
module mix_col_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mix_col_if.slave bus,
  output logic     busy
);

  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    work_q, work_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    run_work;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Each coefficient is an XOR of x, 2x, 4x, 8x, so one xtime chain per byte serves both directions.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv_mode);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    int          r1, r2, r3;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      if (inv_mode)
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                         ^ (x8[r1] ^ x2[r1] ^ a[r1])
                         ^ (x8[r2] ^ x4[r2] ^ a[r2])
                         ^ (x8[r3] ^ a[r3]);
      else
        res[31-8*r -: 8] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
    end
    return res;
  endfunction

  always_comb begin
    run_work = work_q;
    for (int c = 0; c < 4; c++) begin
      if (int'(cnt_q) == c / COLS_PER_CYCLE)
        run_work[127-32*c -: 32] = mix_column(work_q[127-32*c -: 32], mode_q);
    end
  end

  // A finished result handed off in DONE frees the engine for a same-cycle accept.
  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_state = (state_q == S_DONE) ? work_q : '0;
  assign busy          = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_state;
          mode_d  = bus.inv;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d = run_work;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            work_d  = bus.in_state;
            mode_d  = bus.inv;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/mix_col_engine.md
# mix_col_engine

Sequential, parametrised AES MixColumns / InvMixColumns unit operating on a full 128-bit state. It accepts a state over a valid/ready handshake, transforms a configurable number of columns per clock using GF(2^8) constant multipliers (xtime chains, reduction polynomial 0x11b), and presents the result over a second valid/ready handshake. It sits between ShiftRows/InvShiftRows and AddRoundKey in the round datapath and replaces the fixed-coefficient per-byte multipliers with a single shared forward/inverse engine.

## Interface
- COLS_PER_CYCLE, 1, columns processed per RUN cycle; legal values 1, 2 or 4; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state/inv are valid.
- in_ready  output  1  engine can accept a state this cycle.
- in_state  input  128  state; column c = in_state[127-32c -: 32], row 0 is that column's MSB byte.
- inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled only at accept.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts out_state this cycle.
- out_state  output  128  transformed state, same byte ordering as in_state.
- busy  output  1  high in RUN.

## Operation
- Reset (rst_n low, asynchronous): FSM to IDLE; in_ready=1 after reset release, out_valid=0, busy=0, out_state=0, column counter=0, latched mode=0.
- FSM states IDLE, RUN, DONE. N = 4/COLS_PER_CYCLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_state into work register, latch inv, counter=0, go RUN.
- RUN: each cycle replaces columns counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 in the work register with their transform; counter += 1. After the N-th RUN cycle go DONE. in_valid ignored; changes on inv or in_state have no effect.
- DONE: out_valid=1, out_state = work register, held stable while out_ready=0. On out_ready=1: out_valid drops next cycle; if in_valid is also high the new state is accepted in the same cycle (in_ready = IDLE || (DONE && out_ready)) and FSM goes directly to RUN; otherwise to IDLE.
- Forward, column (a0..a3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
- Inverse: b0=0e·a0^0b·a1^0d·a2^09·a3, rotating coefficients for rows 1..3 (b1=09,0e,0b,0d; b2=0d,09,0e,0b; b3=0b,0d,09,0e).
- GF multiply: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00); multiples built as XOR of x, xtime, xtime², xtime³. All arithmetic 8-bit, no carries.
- Counter is log2(N)+1 bits wide, never wraps past N; cleared on every accept.

## Timing
- Accept on edge T; RUN occupies cycles after edges T..T+N-1; out_valid=1 after edge T+N. Latency N+1 cycles from accept to out_valid (COLS_PER_CYCLE=4: 2 cycles; =1: 5 cycles).
- Sustained throughput with out_ready tied high: one state per N+1 cycles.
- in_ready is combinational from FSM state and out_ready only; no path from in_valid to in_ready.
- Reset asserted mid-RUN or in DONE: result discarded, outputs return to reset values immediately; no partial result ever has out_valid=1.

## Test plan
- Forward, COLS_PER_CYCLE=1: in_state=db135345_f20a225c_01010101_c6c6c6c6, inv=0 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 5 cycles after accept.
- Inverse, COLS_PER_CYCLE=4: in_state=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, inv=1 -> out_state=db135345_f20a225c_d4d4d4d5_2d26314c, out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state constant, in_ready=0; then out_ready=1 with in_valid=1 -> next state accepted that cycle, no bubble.
- Mode stability: toggle inv and in_state every cycle during RUN (COLS_PER_CYCLE=2) -> result matches mode and data latched at accept.
- Reset mid-op: deassert rst_n on second RUN cycle -> out_valid=0, out_state=0 immediately; after release in_ready=1 and next transform of 01010101×4 returns 01010101×4.
- Random: 1000 random states, both modes, all three COLS_PER_CYCLE values, random out_ready -> matches reference model; forward then inverse returns original state.
